// File: rtl/csr_reg.sv
// rtl/csr_reg.sv - machine-mode CSR register file with two write ports and 64-bit counters
module csr_reg #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_csr_we_i,
    input  logic [11:0] ex_csr_waddr_i,
    input  logic [31:0] ex_csr_wdata_i,
    input  logic [11:0] ex_csr_raddr_i,
    output logic [31:0] ex_csr_rdata_o,
    output logic        ex_csr_illegal_o,
    input  logic        ctrl_csr_we_i,
    input  logic [11:0] ctrl_csr_waddr_i,
    input  logic [31:0] ctrl_csr_wdata_i,
    input  logic        timer_irq_i,
    input  logic        soft_irq_i,
    input  logic        instr_retire_i,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mip_o
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [31:0] MISA_VAL    = 32'h4000_0100;

    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [2:0]  mie_q, mie_d;
    logic [29:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [29:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        mtip_q, msip_q;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // Port 0 is execute, port 1 is controller; later port overrides so ctrl wins on collisions.
    logic [1:0]       wr_we;
    logic [1:0][11:0] wr_addr;
    logic [1:0][31:0] wr_data;

    assign wr_we   = {ctrl_csr_we_i, ex_csr_we_i};
    assign wr_addr = {ctrl_csr_waddr_i, ex_csr_waddr_i};
    assign wr_data = {ctrl_csr_wdata_i, ex_csr_wdata_i};

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instr_retire_i};
        for (int p = 0; p < 2; p++) begin
            if (wr_we[p]) begin
                case (wr_addr[p])
                    A_MSTATUS: begin
                        mst_mie_d  = wr_data[p][3];
                        mst_mpie_d = wr_data[p][7];
                    end
                    A_MIE:       mie_d = {wr_data[p][11], wr_data[p][7], wr_data[p][3]};
                    A_MTVEC:     mtvec_d = wr_data[p][31:2];
                    A_MSCRATCH:  mscratch_d = wr_data[p];
                    A_MEPC:      mepc_d = wr_data[p][31:2];
                    A_MCAUSE:    mcause_d = wr_data[p];
                    A_MTVAL:     mtval_d = wr_data[p];
                    A_MCYCLE:    mcycle_d[31:0] = wr_data[p];
                    A_MCYCLEH:   mcycle_d[63:32] = wr_data[p];
                    A_MINSTRET:  minstret_d[31:0] = wr_data[p];
                    A_MINSTRETH: minstret_d[63:32] = wr_data[p];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 3'd0;
            mtvec_q    <= MTVEC_RST[31:2];
            mscratch_q <= 32'd0;
            mepc_q     <= 30'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mtip_q     <= 1'b0;
            msip_q     <= 1'b0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mtip_q     <= timer_irq_i;
            msip_q     <= soft_irq_i;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign csr_mstatus_o = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
    assign csr_mie_o     = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
    assign csr_mip_o     = {24'd0, mtip_q, 3'd0, msip_q, 3'd0};
    assign csr_mtvec_o   = {mtvec_q, 2'b00};
    assign csr_mepc_o    = {mepc_q, 2'b00};

    always_comb begin
        ex_csr_rdata_o   = 32'd0;
        ex_csr_illegal_o = 1'b0;
        case (ex_csr_raddr_i)
            A_MSTATUS:   ex_csr_rdata_o = csr_mstatus_o;
            A_MISA:      ex_csr_rdata_o = MISA_VAL;
            A_MIE:       ex_csr_rdata_o = csr_mie_o;
            A_MTVEC:     ex_csr_rdata_o = csr_mtvec_o;
            A_MSCRATCH:  ex_csr_rdata_o = mscratch_q;
            A_MEPC:      ex_csr_rdata_o = csr_mepc_o;
            A_MCAUSE:    ex_csr_rdata_o = mcause_q;
            A_MTVAL:     ex_csr_rdata_o = mtval_q;
            A_MIP:       ex_csr_rdata_o = csr_mip_o;
            A_MCYCLE:    ex_csr_rdata_o = mcycle_q[31:0];
            A_MCYCLEH:   ex_csr_rdata_o = mcycle_q[63:32];
            A_MINSTRET:  ex_csr_rdata_o = minstret_q[31:0];
            A_MINSTRETH: ex_csr_rdata_o = minstret_q[63:32];
            A_MHARTID:   ex_csr_rdata_o = HART_ID;
            default:     ex_csr_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_csr_reg.sv
// tb/tb_csr_reg.sv - directed self-checking bench for csr_reg
module tb_csr_reg;

    logic        clk;
    logic        rst;
    logic        ex_we;
    logic [11:0] ex_waddr;
    logic [31:0] ex_wdata;
    logic [11:0] ex_raddr;
    logic [31:0] ex_rdata;
    logic        ex_illegal;
    logic        ctrl_we;
    logic [11:0] ctrl_waddr;
    logic [31:0] ctrl_wdata;
    logic        timer_irq;
    logic        soft_irq;
    logic        retire;
    logic [31:0] mstatus_o, mepc_o, mtvec_o, mie_o, mip_o;

    int checks = 0;
    int failures = 0;

    csr_reg #(
        .MTVEC_RST(32'h1000_0007),
        .HART_ID  (32'h0000_0005)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ex_csr_we_i     (ex_we),
        .ex_csr_waddr_i  (ex_waddr),
        .ex_csr_wdata_i  (ex_wdata),
        .ex_csr_raddr_i  (ex_raddr),
        .ex_csr_rdata_o  (ex_rdata),
        .ex_csr_illegal_o(ex_illegal),
        .ctrl_csr_we_i   (ctrl_we),
        .ctrl_csr_waddr_i(ctrl_waddr),
        .ctrl_csr_wdata_i(ctrl_wdata),
        .timer_irq_i     (timer_irq),
        .soft_irq_i      (soft_irq),
        .instr_retire_i  (retire),
        .csr_mstatus_o   (mstatus_o),
        .csr_mepc_o      (mepc_o),
        .csr_mtvec_o     (mtvec_o),
        .csr_mie_o       (mie_o),
        .csr_mip_o       (mip_o)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        ex_raddr = addr;
        #1;
        chk(tag, ex_rdata, exp);
        chk({tag, "_illegal"}, {31'd0, ex_illegal}, 32'd0);
    endtask

    task automatic ex_wr(input logic [11:0] addr, input logic [31:0] data);
        ex_we = 1'b1;
        ex_waddr = addr;
        ex_wdata = data;
        step();
        ex_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_raddr = '0;
        ctrl_we = 1'b0; ctrl_waddr = '0; ctrl_wdata = '0;
        timer_irq = 1'b0; soft_irq = 1'b0; retire = 1'b0;
        step();
        step();
        rst = 1'b0;

        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_misa", 12'h301, 32'h4000_0100);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h1000_0004);
        rd("rst_mscratch", 12'h340, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mtval", 12'h343, 32'h0);
        rd("rst_mip", 12'h344, 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);
        rd("rst_minstret", 12'hB02, 32'h0);
        rd("rst_mhartid", 12'hF14, 32'h5);
        chk("rst_mstatus_o", mstatus_o, 32'h0000_1800);
        chk("rst_mtvec_o", mtvec_o, 32'h1000_0004);

        ex_wr(12'h305, 32'hFFFF_FFFF);
        rd("wr_mtvec", 12'h305, 32'hFFFF_FFFC);
        chk("wr_mtvec_o", mtvec_o, 32'hFFFF_FFFC);
        ex_wr(12'h341, 32'h8000_0003);
        rd("wr_mepc", 12'h341, 32'h8000_0000);
        chk("wr_mepc_o", mepc_o, 32'h8000_0000);
        ex_wr(12'h300, 32'hFFFF_FFFF);
        rd("wr_mstatus", 12'h300, 32'h0000_1888);
        ex_wr(12'h304, 32'hFFFF_FFFF);
        rd("wr_mie", 12'h304, 32'h0000_0888);
        chk("wr_mie_o", mie_o, 32'h0000_0888);

        ctrl_we = 1'b1; ctrl_waddr = 12'h300; ctrl_wdata = 32'h0;
        ex_we = 1'b1; ex_waddr = 12'h300; ex_wdata = 32'h8;
        step();
        rd("coll_mstatus", 12'h300, 32'h0000_1800);
        ctrl_waddr = 12'h342; ctrl_wdata = 32'h8000_0007;
        ex_waddr = 12'h340; ex_wdata = 32'h0000_1234;
        step();
        ctrl_we = 1'b0; ex_we = 1'b0;
        rd("dual_mcause", 12'h342, 32'h8000_0007);
        rd("dual_mscratch", 12'h340, 32'h0000_1234);

        ex_wr(12'hB80, 32'h0);
        ex_wr(12'hB00, 32'hFFFF_FFFF);
        rd("cyc_lo_pre", 12'hB00, 32'hFFFF_FFFF);
        rd("cyc_hi_pre", 12'hB80, 32'h0);
        step();
        rd("cyc_lo_wrap", 12'hB00, 32'h0);
        rd("cyc_hi_carry", 12'hB80, 32'h1);
        ex_wr(12'hB80, 32'hFFFF_FFFF);
        ex_wr(12'hB00, 32'hFFFF_FFFF);
        step();
        rd("cyc64_wrap_lo", 12'hB00, 32'h0);
        rd("cyc64_wrap_hi", 12'hB80, 32'h0);

        retire = 1'b1;
        for (int i = 0; i < 5; i++) step();
        retire = 1'b0;
        step();
        step();
        rd("minstret", 12'hB02, 32'h5);
        rd("minstreth", 12'hB82, 32'h0);

        timer_irq = 1'b1;
        #1;
        chk("mip_latency", mip_o, 32'h0);
        step();
        chk("mip_mtip", mip_o, 32'h80);
        ex_wr(12'h344, 32'h0);
        chk("mip_wr_ignored", mip_o, 32'h80);
        soft_irq = 1'b1;
        step();
        chk("mip_both", mip_o, 32'h88);
        rd("rd_mip", 12'h344, 32'h88);

        ex_raddr = 12'h7C0;
        #1;
        chk("ill_rdata", ex_rdata, 32'h0);
        chk("ill_flag", {31'd0, ex_illegal}, 32'h1);
        ex_wr(12'h301, 32'h0);
        rd("misa_ro", 12'h301, 32'h4000_0100);
        ex_wr(12'hF14, 32'hFFFF_FFFF);
        rd("mhartid_ro", 12'hF14, 32'h5);

        rst = 1'b1;
        ex_we = 1'b1; ex_waddr = 12'h340; ex_wdata = 32'hDEAD_BEEF;
        retire = 1'b1;
        step();
        rst = 1'b0; ex_we = 1'b0; retire = 1'b0; timer_irq = 1'b0; soft_irq = 1'b0;
        chk("rr_mstatus_o", mstatus_o, 32'h0000_1800);
        chk("rr_mtvec_o", mtvec_o, 32'h1000_0004);
        chk("rr_mepc_o", mepc_o, 32'h0);
        chk("rr_mie_o", mie_o, 32'h0);
        chk("rr_mip_o", mip_o, 32'h0);
        rd("rr_mscratch", 12'h340, 32'h0);
        rd("rr_mcause", 12'h342, 32'h0);
        rd("rr_mcycle", 12'hB00, 32'h0);
        rd("rr_minstret", 12'hB02, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_reg.md
Name: csr_reg

Overview:
- Machine-mode CSR register file for the milano RV32I core.
- Consumes the CSR write port driven by the exception/interrupt controller and the CSR write port driven by the execute stage.
- Serves combinational CSR reads to the execute stage.
- Exports mstatus/mepc/mtvec/mie/mip back to the controller; also implements mcycle/minstret counters and samples the timer/software interrupt lines into mip.

Parameters:
MTVEC_RST, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored, forced 0)
HART_ID, 32'h0, value returned by mhartid

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
ex_csr_we_i  input  1  execute-stage CSR write enable
ex_csr_waddr_i  input  12  execute-stage write address
ex_csr_wdata_i  input  32  execute-stage write data (already combined for CSRRS/CSRRC)
ex_csr_raddr_i  input  12  execute-stage read address
ex_csr_rdata_o  output  32  read data, combinational from ex_csr_raddr_i
ex_csr_illegal_o  output  1  ex_csr_raddr_i not implemented
ctrl_csr_we_i  input  1  controller CSR write enable
ctrl_csr_waddr_i  input  12  controller write address
ctrl_csr_wdata_i  input  32  controller write data
timer_irq_i  input  1  machine timer interrupt level
soft_irq_i  input  1  machine software interrupt level
instr_retire_i  input  1  one instruction retired this cycle
csr_mstatus_o  output  32  current mstatus
csr_mepc_o  output  32  current mepc
csr_mtvec_o  output  32  current mtvec
csr_mie_o  output  32  current mie
csr_mip_o  output  32  current mip

Behaviour:
- Implemented CSRs (addr: writable bits / reset value):
  - mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] read-only 2'b11; other bits 0. Reset 0x0000_1800.
  - misa 0x301: read-only 0x4000_0100.
  - mie 0x304: bits 3, 7, 11 writable. Reset 0.
  - mtvec 0x305: [31:2] writable, [1:0] read 0. Reset {MTVEC_RST[31:2], 2'b00}.
  - mscratch 0x340: 32-bit. Reset 0.
  - mepc 0x341: [31:2] writable, [1:0] read 0. Reset 0.
  - mcause 0x342: 32-bit. Reset 0.
  - mtval 0x343: 32-bit. Reset 0.
  - mip 0x344: read-only; bit7 MTIP, bit3 MSIP. Reset 0.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: 64-bit counters, reset 0.
  - mhartid 0xF14: read-only HART_ID.
- Writes take effect at the rising edge when we is high: new value visible on outputs and reads in the next cycle. No write-to-read bypass.
- Writes to read-only CSRs or unimplemented addresses are silently dropped.
- Simultaneous ctrl and ex writes:
  - Same address: ctrl write wins, ex write dropped.
  - Different addresses: both are performed.
- mip: MTIP <= timer_irq_i and MSIP <= soft_irq_i, registered every cycle (one-cycle latency). Software writes are ignored.
- mcycle: next = cnt + 1 every cycle; then a write to the low half replaces next[31:0], and a write to the high half replaces next[63:32].
- minstret: same rule, but +1 only when instr_retire_i = 1.
- 64-bit carry from low to high half is required; wrap at 2^64 to 0.
- Read path:
  - ex_csr_rdata_o = current register value with read-only/zero fields applied.
  - Unimplemented address: rdata = 0 and ex_csr_illegal_o = 1; otherwise illegal = 0.
  - Illegal is purely a read decode and does not depend on we.
- Reset: rst_i high at an edge forces every register to its reset value regardless of concurrent writes, counting or IRQ levels. Outputs are registered, so csr_*_o hold reset values in the cycle after that edge.
- Outputs csr_*_o are driven directly from registers; no combinational path from any input.

Test Plan:
- Reset: hold rst_i 2 cycles, then read each CSR -> mstatus 0x1800, misa 0x4000_0100, mtvec MTVEC_RST&~3, all others 0, illegal 0.
- ex write mtvec 0xFFFF_FFFF, mepc 0x8000_0003, mstatus 0xFFFF_FFFF -> reads 0xFFFF_FFFC, 0x8000_0000, 0x0000_1888; mie write 0xFFFF_FFFF -> 0x0000_0888.
- Same cycle, ctrl writes mstatus 0x0 and ex writes mstatus 0x8 -> mstatus 0x1800. Same cycle, ctrl writes mcause 0x8000_0007 and ex writes mscratch 0x1234 -> both visible next cycle.
- ex write mcycle 0xFFFF_FFFF and mcycleh 0x0 (consecutive cycles) -> counter carries: mcycleh reads 1, mcycle reads small value after the wrap. With instr_retire_i toggled for 5 cycles, minstret = 5.
- timer_irq_i = 1 at edge N -> csr_mip_o = 0x80 after edge N. ex write mip 0x0 -> still 0x80. soft_irq_i = 1 -> 0x88.
- Read 0x7C0 -> rdata 0, illegal 1; write 0x301 -> misa unchanged. Assert rst_i mid-count with a concurrent write -> all reset values next cycle.
